// File: rtl/dline_pkg.sv
// +----------------------------------------------------------------------------+
// | dline_pkg : shared helpers for prog_delay_line (parity, pointer arithmetic)|
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

package dline_pkg;

  localparam int DLINE_DEPTH_DEFAULT = 16;
  // Widest channel the parity helper covers; narrower words are zero-extended.
  localparam int PAR_MAXW = 64;

  function automatic logic even_par(input logic [PAR_MAXW-1:0] d);
    return ^d;
  endfunction

  // (a - b) mod depth, for a < depth and b < depth.
  function automatic int unsigned ptr_sub(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned depth);
    return (a >= b) ? (a - b) : (a + depth - b);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dline_ram.sv
// +----------------------------------------------------------------------------+
// | dline_ram : DEPTH-entry buffer, synchronous write, asynchronous read       |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module dline_ram #(
  parameter int DEPTH  = 16,
  parameter int WORD_W = 32,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/prog_delay_line.sv
// +----------------------------------------------------------------------------+
// | prog_delay_line : multi-channel programmable delay line (1..DEPTH cycles)  |
// | Optional per-channel parity storage/check with `DLINE_PARITY_EN.           |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module prog_delay_line
  import dline_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int DEPTH = DLINE_DEPTH_DEFAULT,
  parameter int DW    = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 en,
  input  logic [NCH*WIDTH-1:0] din,
  input  logic                 dly_load,
  input  logic [DW-1:0]        dly_val,
  output logic [NCH*WIDTH-1:0] dout,
  output logic                 dout_vld,
  output logic                 cfg_err,
  output logic                 par_err
);

  localparam int DATA_W = NCH * WIDTH;
  localparam int AW     = $clog2(DEPTH);
`ifdef DLINE_PARITY_EN
  localparam int WORD_W = DATA_W + NCH;
`else
  localparam int WORD_W = DATA_W;
`endif
  localparam logic [DW-1:0] ONE     = DW'(1);
  localparam logic [DW-1:0] DEPTH_C = DW'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  logic [AW-1:0]     wptr_q, wptr_d;
  logic [DW-1:0]     fill_q, fill_d;
  logic [DW-1:0]     dly_q, dly_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              vld_q, vld_d;
  logic              cfg_q, cfg_d;

  logic              dly_legal;
  logic [DW-1:0]     d_eff;
  logic [AW-1:0]     raddr;
  logic [WORD_W-1:0] wr_word, rd_word;

  // A load takes effect on the same edge, so every read-side decision uses d_eff.
  assign dly_legal = (dly_val != '0) && (dly_val <= DEPTH_C);
  assign d_eff     = dly_load ? (dly_legal ? dly_val : ONE) : dly_q;
  assign raddr     = AW'(ptr_sub(32'(wptr_q), 32'(d_eff) - 32'd1, DEPTH));

  dline_ram #(
    .DEPTH  (DEPTH),
    .WORD_W (WORD_W),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (en),
    .waddr_i (wptr_q),
    .wdata_i (wr_word),
    .raddr_i (raddr),
    .rdata_o (rd_word)
  );

  always_comb begin
    wptr_d = wptr_q;
    fill_d = fill_q;
    dly_d  = d_eff;
    dout_d = dout_q;
    vld_d  = vld_q;
    cfg_d  = cfg_q | (dly_load & ~dly_legal);
    if (dly_load) fill_d = '0;
    if (en) begin
      wptr_d = (wptr_q == LAST) ? '0 : wptr_q + AW'(1);
      if (dly_load)            fill_d = ONE;
      else if (fill_q < d_eff) fill_d = fill_q + ONE;
      dout_d = (d_eff == ONE) ? din : rd_word[DATA_W-1:0];
    end
    if (en || dly_load) vld_d = (fill_d >= d_eff);
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      wptr_q <= '0;
      fill_q <= '0;
      dly_q  <= ONE;
      dout_q <= '0;
      vld_q  <= 1'b0;
      cfg_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      fill_q <= fill_d;
      dly_q  <= dly_d;
      dout_q <= dout_d;
      vld_q  <= vld_d;
      cfg_q  <= cfg_d;
    end
  end

`ifdef DLINE_PARITY_EN
  logic [NCH-1:0] wpar, rbad;
  logic           par_hit_q, par_hit_d;
  logic           perr_q, perr_d;

  for (genvar c = 0; c < NCH; c++) begin : g_par
    assign wpar[c] = even_par(PAR_MAXW'(din[c*WIDTH +: WIDTH]));
    assign rbad[c] = even_par(PAR_MAXW'(rd_word[c*WIDTH +: WIDTH])) != rd_word[DATA_W+c];
  end

  assign wr_word = {wpar, din};

  // Mismatch is captured with the read, then folded into the sticky flag an edge later.
  always_comb begin
    par_hit_d = en && (d_eff != ONE) && (|rbad);
    perr_d    = perr_q | par_hit_q;
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      par_hit_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      par_hit_q <= par_hit_d;
      perr_q    <= perr_d;
    end
  end

  assign par_err = perr_q;
`else
  assign wr_word = din;
  assign par_err = 1'b0;
`endif

  assign dout     = dout_q;
  assign dout_vld = vld_q;
  assign cfg_err  = cfg_q;

endmodule

`default_nettype wire

// File: tb/tb_prog_delay_line.sv
// +----------------------------------------------------------------------------+
// | tb_prog_delay_line : scoreboard bench for prog_delay_line                  |
// | Revision           : 1.0                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_prog_delay_line;

  localparam int WIDTH  = 8;
  localparam int NCH    = 4;
  localparam int DEPTH  = 16;
  localparam int DW     = $clog2(DEPTH + 1);
  localparam int DATA_W = NCH * WIDTH;

  logic              clk = 1'b0;
  logic              rstb;
  logic              en;
  logic [DATA_W-1:0] din;
  logic              dly_load;
  logic [DW-1:0]     dly_val;
  logic [DATA_W-1:0] dout;
  logic              dout_vld;
  logic              cfg_err;
  logic              par_err;

  prog_delay_line #(
    .WIDTH (WIDTH),
    .NCH   (NCH),
    .DEPTH (DEPTH),
    .DW    (DW)
  ) dut (
    .clk      (clk),
    .rstb     (rstb),
    .en       (en),
    .din      (din),
    .dly_load (dly_load),
    .dly_val  (dly_val),
    .dout     (dout),
    .dout_vld (dout_vld),
    .cfg_err  (cfg_err),
    .par_err  (par_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              vld;
    logic              known;
    logic [DATA_W-1:0] dout;
    logic              cfg;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  int                m_d;
  logic              m_vld, m_known, m_cfg;
  logic [DATA_W-1:0] m_dout;
  logic [DATA_W-1:0] m_hist[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One clock: drive inputs, push the model's expectation, then pop and compare.
  task automatic step(input string tag, input bit rst, input bit e,
                      input logic [DATA_W-1:0] d, input bit ld, input int v);
    exp_t x;
    @(negedge clk);
    rstb     = !rst;
    en       = e;
    din      = d;
    dly_load = ld;
    dly_val  = DW'(v);
    if (rst) begin
      m_d = 1; m_cfg = 1'b0; m_vld = 1'b0; m_known = 1'b1; m_dout = '0;
      m_hist.delete();
    end else begin
      if (ld) begin
        m_hist.delete();
        m_vld = 1'b0;
        if (v >= 1 && v <= DEPTH) m_d = v;
        else begin m_d = 1; m_cfg = 1'b1; end
      end
      if (e) begin
        m_hist.push_back(d);
        if (m_hist.size() >= m_d) begin
          m_vld = 1'b1; m_known = 1'b1;
          m_dout = m_hist[m_hist.size() - m_d];
        end else begin
          m_vld = 1'b0; m_known = 1'b0;
        end
      end
    end
    x.vld = m_vld; x.known = m_known; x.dout = m_dout; x.cfg = m_cfg;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    check({tag, ".vld"}, 64'(dout_vld), 64'(x.vld));
    check({tag, ".cfg"}, 64'(cfg_err), 64'(x.cfg));
`ifndef DLINE_PARITY_EN
    check({tag, ".par"}, 64'(par_err), 64'd0);
`endif
    if (x.known) check({tag, ".dout"}, 64'(dout), 64'(x.dout));
  endtask

  initial begin
    rstb = 1'b0; en = 1'b0; din = '0; dly_load = 1'b0; dly_val = '0;

    // Reset wins over a simultaneous load and enable.
    step("rst", 1, 1, 32'hAA, 1, 7);
    step("rst", 1, 0, 32'h0, 0, 0);
    step("idle", 0, 0, 32'h0, 0, 0);

    for (int i = 0; i < 20; i++) step("d1", 0, 1, DATA_W'(i), 0, 0);

    step("ld5", 0, 0, 32'h0, 1, 5);
    for (int i = 0; i < 32; i++) step("d5", 0, 1, DATA_W'(32'h10 + i), 0, 0);

    step("ld16", 0, 0, 32'h0, 1, 16);
    for (int i = 0; i < 50; i++) step("d16", 0, (i % 2) == 0, DATA_W'($urandom), 0, 0);

    step("ld0", 0, 1, 32'h55, 1, 0);
    for (int i = 0; i < 4; i++) step("d0", 0, 1, DATA_W'(32'h60 + i), 0, 0);
    step("ld17", 0, 0, 32'h0, 1, 17);
    for (int i = 0; i < 4; i++) step("d17", 0, 1, DATA_W'(32'h70 + i), 0, 0);

    step("rst2", 1, 0, 32'h0, 0, 0);
    step("ld3", 0, 0, 32'h0, 1, 3);
    for (int i = 0; i < 10; i++) step("d3", 0, 1, DATA_W'(32'h80 + i), 0, 0);
    step("ld6en", 0, 1, 32'h90, 1, 6);
    for (int i = 0; i < 10; i++) step("d6", 0, 1, DATA_W'(32'h91 + i), 0, 0);
    step("rstmid", 1, 1, 32'hFF, 1, 9);
    for (int i = 0; i < 3; i++) step("post", 0, 1, DATA_W'(32'hA0 + i), 0, 0);

    for (int i = 0; i < 80; i++)
      step("rnd", 0, $urandom_range(0, 3) != 0, DATA_W'($urandom),
           $urandom_range(0, 9) == 0, int'($urandom_range(0, 17)));

`ifdef DLINE_PARITY_EN
    begin
      bit seen;
      seen = 1'b0;
      step("prst", 1, 0, 32'h0, 0, 0);
      step("pld4", 0, 0, 32'h0, 1, 4);
      for (int i = 0; i < 20; i++) step("pd4", 0, 1, DATA_W'(32'hB0 + i), 0, 0);
      check("par.clean", 64'(par_err), 64'd0);
      for (int i = 0; i < DEPTH; i++) dut.u_ram.mem_q[i][0] = ~dut.u_ram.mem_q[i][0];
      for (int i = 0; i < 6 && !seen; i++) begin
        @(negedge clk);
        en = 1'b1; dly_load = 1'b0; din = DATA_W'(32'hC0 + i);
        @(posedge clk);
        #1;
        if (par_err) seen = 1'b1;
      end
      check("par.flip", 64'(seen), 64'd1);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/prog_delay_line.md
# prog_delay_line

Clocked, parametrised, multi-channel delay line. It replaces fixed analogue delay cells wherever a data path needs a programmable number of whole clock cycles of latency, for example hit-data alignment against trigger latency in the strip readout front end. All NCH channels share one circular buffer and one run-time delay setting. The block reports when its output is valid, and optionally checks parity on stored words.

## Interface
Parameters:
- WIDTH, 8: bits per channel.
- NCH, 4: number of channels.
- DEPTH, 16: maximum delay in cycles (≥2).
- DW, $clog2(DEPTH+1): width of the delay setting.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rstb  in  1  reset; synchronous, active-low.
- en  in  1  advance strobe; delay is counted in enabled cycles only.
- din  in  NCH*WIDTH  input data, channel c at bits [c*WIDTH +: WIDTH].
- dly_load  in  1  loads dly_val into the delay register.
- dly_val  in  DW  requested delay, legal range 1..DEPTH.
- dout  out  NCH*WIDTH  delayed data, registered.
- dout_vld  out  1  dout holds a sample written since the last reset or load.
- cfg_err  out  1  sticky flag: an illegal dly_val was loaded.
- par_err  out  1  sticky flag, parity mismatch on a read word (DLINE_PARITY_EN only; otherwise tied 0).

## Operation
- Reset (rstb=0 at an edge) sets:
  - dout=0, dout_vld=0, cfg_err=0, par_err=0;
  - write pointer=0, fill counter=0, delay register D=1.
  - Buffer contents are not cleared.
- Delay semantics: a sample captured at enabled edge k appears on dout after enabled edge k+D-1.
  - D=1 is a plain register stage.
  - D=DEPTH uses the full buffer.
- Each enabled edge writes din at the write pointer, then increments the pointer modulo DEPTH (wraps DEPTH-1→0).
  - dout ← din when D=1.
  - Otherwise dout ← mem[(wptr − (D−1)) mod DEPTH].
- en=0: pointer, fill counter, dout and dout_vld all hold.
- Fill counter: counts enabled edges and saturates at D. dout_vld=1 once fill ≥ D.
- dly_load (sampled at an edge, independent of en):
  - dly_val 1..DEPTH: D ← dly_val.
  - dly_val 0 or >DEPTH: D ← 1 and cfg_err ← 1.
  - In both cases the fill counter restarts and dout_vld clears at the same edge. The write pointer is not reset.
- dly_load together with en: the load applies first. The sample written on that edge counts as fill sample 1 under the new D, and dout takes a value computed with the new D. dout_vld still goes 0 at that edge unless the new D=1, in which case it is 1.
- cfg_err and par_err clear only on reset.
- Reset asserted mid-operation overrides en and dly_load at the same edge.

## Timing
- Latency is exactly D enabled cycles, edge to dout.
- dout_vld rises after the D-th enabled edge following reset or load.
- dout changes only on enabled edges, or on reset.
- No combinational path from any input to any output.

## Configuration
- DLINE_PARITY_EN defined:
  - Each buffer word stores one even-parity bit per channel, computed from din at write time.
  - On every enabled read with D>1, parity is rechecked on the word read. A mismatch on any channel sets par_err one edge later.
  - D=1 bypasses the buffer, so no check is made.
- Undefined: no parity storage, and par_err is constant 0.

## Structure
- Package dline_pkg holds:
  - the parity function;
  - the pointer-arithmetic function (mod-DEPTH subtract);
  - a localparam for the default DEPTH.
- Sub-module dline_ram: DEPTH × (NCH*WIDTH [+NCH parity]) storage with one synchronous write and one asynchronous read port. The top level holds pointers, the fill counter, the delay register, output registers and the flags.

## Test plan
- Reset, then 20 enabled cycles with din = cycle index, D=1 → dout_vld=1 after edge 1, dout=din of the same edge; reset values all 0.
- Load D=5, drive din=0x10..0x2F on each enabled edge → dout_vld rises after the 5th edge; dout after edge n equals din of edge n−4, including across the pointer wrap at 16.
- D=16 (DEPTH) with en toggled 1,0,1,0 → dout advances only on enabled edges; observed delay is 16 enabled edges.
- Load D=0, then D=17 → D=1 behaviour after each load; cfg_err=1 and remains 1 until reset.
- While D=3 streaming valid data, pulse dly_load=1 with dly_val=6 together with en=1 → dout_vld drops at that edge and rises again 5 enabled edges later with correct 6-cycle alignment; reset asserted mid-stream clears all outputs at the next edge.
- DLINE_PARITY_EN, D=4: force a bit flip in one dline_ram word → par_err=1 on the edge after the word is read; without the macro, par_err stays 0.
